// File: rtl/hex_score_display_pkg.sv
// hex_display_pkg: types, constants and the segment decode function shared by
// the hex_score_display block and its seg7_decode sub-module.
//   state_t    : conversion FSM states (IDLE, SHIFT, COMMIT)
//   SEG_BLANK  : active-low pattern with every segment off
//   SEG_DASH   : active-low pattern with only segment g lit
//   seg7_of()  : 4-bit BCD digit -> 7-bit active-low segments, bit order g..a
package hex_display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    function automatic logic [6:0] seg7_of(input logic [3:0] bcd4);
        logic [6:0] seg;
        case (bcd4)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex_score_display_if.sv
// hex_score_display_if: request/result bundle between the game logic and the
// score display driver.
//   value    : unsigned binary score (sampled on an accepted load)
//   load     : start-conversion strobe
//   blank    : level, forces every digit dark
//   busy     : conversion in flight
//   done     : one-cycle pulse when a new result is committed
//   overflow : committed result did not fit in NUM_DIGITS
//   bcd      : committed BCD digits, digit 0 at [3:0]
//   hex_out  : active-low segments, digit i at [7i+6:7i]
// master = requester (game logic / bench), slave = hex_score_display.
interface hex_score_display_if #(
    parameter int BIN_WIDTH  = 12,
    parameter int NUM_DIGITS = 4
);
    logic [BIN_WIDTH-1:0]    value;
    logic                    load;
    logic                    blank;
    logic                    busy;
    logic                    done;
    logic                    overflow;
    logic [4*NUM_DIGITS-1:0] bcd;
    logic [7*NUM_DIGITS-1:0] hex_out;

    modport master (
        output value, load, blank,
        input  busy, done, overflow, bcd, hex_out
    );

    modport slave (
        input  value, load, blank,
        output busy, done, overflow, bcd, hex_out
    );
endinterface

// File: rtl/hex_score_display_seg7_decode.sv
// seg7_decode: combinational BCD digit to active-low seven-segment decoder.
//   bcd4 : 4-bit BCD digit (10..15 decode to all segments off)
//   seg  : active-low segments, bit order g..a (bit 0 = a)
module seg7_decode
    import hex_display_pkg::*;
(
    input  logic [3:0] bcd4,
    output logic [6:0] seg
);
    assign seg = seg7_of(bcd4);
endmodule

// File: rtl/hex_score_display.sv
// hex_score_display: sequential binary-to-seven-segment score driver.
// A load captures the binary score; a shift-add-3 engine converts it to BCD at
// one bit per cycle, then the result, overflow flag and segment image are
// committed together so the display never shows a partial conversion.
//   CLOCK_50 : system clock, rising edge
//   resetn   : asynchronous active-low reset
//   bus      : hex_score_display_if slave (value/load/blank in,
//              busy/done/overflow/bcd/hex_out out)
module hex_score_display
    import hex_display_pkg::*;
#(
    parameter int BIN_WIDTH     = 12,
    parameter int NUM_DIGITS    = 4,
    parameter int BLANK_LEADING = 1
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    hex_score_display_if.slave bus
);
    localparam int CW   = $clog2(BIN_WIDTH + 1);
    localparam int BCDW = 4 * NUM_DIGITS;
    localparam logic [CW-1:0] LAST_SHIFT = CW'(BIN_WIDTH - 1);
    localparam logic BLANK_LZ = (BLANK_LEADING != 0);

    state_t state;
    state_t state_next;

    logic                 load_acc;
    logic                 shift_en;
    logic                 commit_en;

    logic [BIN_WIDTH-1:0] bin_sr;
    logic [BCDW-1:0]      work;
    logic [BCDW-1:0]      work_adj;
    logic [CW-1:0]        count;
    logic                 ovf_sticky;

    logic [BCDW-1:0]      bcd_q;
    logic                 ovf_q;
    logic                 done_q;
    logic                 shown_q;

    logic [7*NUM_DIGITS-1:0] dec;
    logic [NUM_DIGITS-1:0]   keep;
    logic                    seen;
    logic [7*NUM_DIGITS-1:0] hex;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.load) state_next = SHIFT;
            SHIFT:   if (count == LAST_SHIFT) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs / strobes ----------------
    always_comb begin
        load_acc  = (state == IDLE) && bus.load;
        shift_en  = (state == SHIFT);
        commit_en = (state == COMMIT);
        bus.busy  = (state != IDLE);
    end

    // Add 3 to every nibble >= 5 so the following left shift doubles in decimal.
    always_comb begin
        work_adj = work;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (work[4*i +: 4] >= 4'd5) begin
                work_adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
            end
        end
    end

    // ---------------- conversion datapath ----------------
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            bin_sr     <= '0;
            work       <= '0;
            count      <= '0;
            ovf_sticky <= 1'b0;
        end else if (load_acc) begin
            bin_sr     <= bus.value;
            work       <= '0;
            count      <= '0;
            ovf_sticky <= 1'b0;
        end else if (shift_en) begin
            // A 1 leaving the top nibble means the value needs another digit.
            {work, bin_sr} <= {work_adj[BCDW-2:0], bin_sr, 1'b0};
            ovf_sticky     <= ovf_sticky | work_adj[BCDW-1];
            count          <= count + 1'b1;
        end
    end

    // ---------------- commit registers ----------------
    // shown_q keeps the digits dark until the first result after reset, so the
    // reset image is all-off rather than a decoded "0".
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            shown_q <= 1'b0;
        end else begin
            done_q <= commit_en;
            if (commit_en) begin
                bcd_q   <= work;
                ovf_q   <= ovf_sticky;
                shown_q <= 1'b1;
            end
        end
    end

    // ---------------- display ----------------
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        seg7_decode u_dec (
            .bcd4 (bcd_q[4*g +: 4]),
            .seg  (dec[7*g +: 7])
        );
    end

    // Scan from the top digit down: a digit is shown once any digit at or
    // above it is nonzero; digit 0 is always shown.
    always_comb begin
        keep = '0;
        seen = 1'b0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            seen = seen
                 | (bcd_q[4*(NUM_DIGITS-1-k) +: 4] != 4'd0)
                 | (k == NUM_DIGITS - 1);
            keep[NUM_DIGITS-1-k] = seen | ~BLANK_LZ;
        end
    end

    always_comb begin
        hex = '1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (bus.blank || !shown_q) begin
                hex[7*i +: 7] = SEG_BLANK;
            end else if (ovf_q) begin
                hex[7*i +: 7] = SEG_DASH;
            end else if (keep[i]) begin
                hex[7*i +: 7] = dec[7*i +: 7];
            end else begin
                hex[7*i +: 7] = SEG_BLANK;
            end
        end
    end

    assign bus.done     = done_q;
    assign bus.overflow = ovf_q;
    assign bus.bcd      = bcd_q;
    assign bus.hex_out  = hex;

endmodule

// File: doc/hex_score_display.md
# hex_score_display

Parametrised, sequential binary-to-seven-segment display driver for the DE1-SoC HEX digits. A `load` strobe captures an unsigned binary score, and an iterative shift-add-3 (double-dabble) engine converts it to BCD, one bit per cycle. The result is committed atomically to the digit outputs, with optional leading-zero blanking and an overflow indication. It replaces per-mode combinational divide/modulo digit splitting in the game top level, so scores of any width can be shown on any number of digits without divider logic.

## Interface
- `BIN_WIDTH`, 12: width of the unsigned binary input.
- `NUM_DIGITS`, 4: number of decimal digits and HEX displays driven.
- `BLANK_LEADING`, 1: 1 = blank zeros above the most significant nonzero digit; 0 = show all digits.
- `CLOCK_50` input 1: system clock. All logic uses the rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `value` input BIN_WIDTH: unsigned binary value to display. Sampled only on an accepted `load`.
- `load` input 1: start-conversion strobe.
- `blank` input 1: level. 1 forces all digits off; the result registers are kept.
- `busy` output 1: high while a conversion is in flight.
- `done` output 1: one-cycle pulse when a new result is committed.
- `overflow` output 1: committed result did not fit in NUM_DIGITS.
- `bcd` output 4*NUM_DIGITS: committed BCD digits. Digit 0 is at [3:0].
- `hex_out` output 7*NUM_DIGITS: active-low segments. Digit i is at [7i+6:7i]; bit order is g..a (bit 0 = a).

## Operation
- States:
  - IDLE → SHIFT when `load` is sampled high. This captures `value` into the shift register, clears the working BCD and the sticky overflow flag, and sets count=0.
  - SHIFT, each cycle: add 3 to every working BCD nibble ≥5, then shift {bcd, bin} left by 1 and increment count. Leave for COMMIT after the BIN_WIDTH-th shift.
  - COMMIT: latch working BCD → `bcd` and sticky flag → `overflow`, pulse `done`, return to IDLE.
- Overflow: sticky; set when a 1 is shifted out of the top working nibble, i.e. the value is ≥10^NUM_DIGITS.
- `load` outside IDLE is ignored. No queuing, and `value` is not resampled.
- Display mapping:
  - `blank`=1: all digits show 7'h7F.
  - Else `overflow`=1: all digits show a dash, 7'h3F.
  - Else each digit is decoded from `bcd`. With BLANK_LEADING=1, digits above the highest nonzero digit show 7'h7F. Digit 0 is never blanked, so a value of 0 shows "0".
- Decoder, active-low: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex). Codes 10–15 cannot be committed; they decode to 7'h7F.
- Reset values: `busy`=0, `done`=0, `overflow`=0, `bcd`=0, `hex_out` all 7'h7F (dark), state IDLE.

## Timing
- `load` sampled at edge k. Shifts occur at edges k+1 … k+BIN_WIDTH. Commit happens at edge k+BIN_WIDTH+1.
- `done`, `bcd`, `overflow` and `hex_out` update together after edge k+BIN_WIDTH+1. Latency is 13 cycles at the default.
- `busy` is high from after edge k through the COMMIT cycle and falls with the IDLE return.
- `load` high during the COMMIT cycle is ignored. The earliest next accepted load is the first IDLE cycle, giving throughput of one conversion per BIN_WIDTH+2 cycles.
- Outputs hold the previous result for the whole conversion, so the display never flickers.
- `blank` acts combinationally on `hex_out` through the registered result, with no cycle penalty.
- `resetn` asserted mid-conversion: the conversion is abandoned immediately, no `done` is issued, and all outputs return to reset values.
- Counter width is $clog2(BIN_WIDTH+1). The working BCD register is 4*NUM_DIGITS bits.

## Structure
- Package `hex_display_pkg` holds:
  - state enum (IDLE, SHIFT, COMMIT);
  - constants SEG_BLANK=7'h7F and SEG_DASH=7'h3F;
  - function `seg7_of(bcd4)`.
- One combinational sub-module, `seg7_decode` (4-bit BCD → 7-bit active-low), instantiated NUM_DIGITS times in a generate loop. The leading-blank and overflow muxes sit in the parent.
- The FSM, counter, shift register and commit registers are in `hex_score_display`.

## Test plan
- Reset: assert `resetn`=0 mid-conversion → `hex_out` all 7'h7F, `busy`=0, `done` never pulses, `bcd`=0.
- Defaults, `value`=1234, `load` pulse → `done` exactly 13 cycles later; `bcd`=16'h1234; digits 3..0 = 79, 24, 30, 19; `overflow`=0.
- Blanking: `value`=7 → digit 0 = 78, digits 1–3 = 7F. `value`=0 → digit 0 = 40, others 7F. With BLANK_LEADING=0, `value`=7 → digits = 40, 40, 40, 78.
- Overflow: BIN_WIDTH=14, `value`=10000 → `overflow`=1, all digits 3F. Then `value`=9999 → `overflow`=0, digits all 10.
- Handshake: a second `load` with `value`=55 while `busy` → ignored, first result committed. `load` on the first IDLE cycle after `done` → accepted, `done` after 13 more cycles.
- `blank`=1 after a committed 1234 → all 7F, `bcd` unchanged. `blank`=0 → 1234 shown again on the same cycle.
